csr_commit_unit: RTL and testbench

// - Consumer side of the CSR commit path. At commit it takes one pending CSR op, performs the

---
 rtl/ariane_pkg.sv | 57 +++++
 rtl/csr_commit_unit.sv | 219 +++++++++++++++++++++
 tb/tb_csr_commit_unit.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ariane_pkg.sv
// Shared types and helpers for the CSR commit path: op/exception encodings
// and the read-modify-write rule used when an op updates a CSR.
package ariane_pkg;

  localparam int unsigned CSR_XLEN     = 64;
  // Address bits [11:10] equal to this value mark a read-only CSR.
  localparam logic [1:0]  CSR_RO_FIELD = 2'b11;

  typedef enum logic [1:0] {
    CSR_READ  = 2'd0,
    CSR_WRITE = 2'd1,
    CSR_SET   = 2'd2,
    CSR_CLEAR = 2'd3
  } csr_op_e;

  typedef enum logic [1:0] {
    ILLEGAL_PRIV = 2'd0,
    ILLEGAL_RO   = 2'd1,
    BUS_ERR      = 2'd2,
    TIMEOUT      = 2'd3
  } csr_ex_e;

  typedef struct packed {
    logic [CSR_XLEN-1:0] value;
    logic                writes;
  } csr_rmw_t;

  // New CSR value and whether the op actually modifies the CSR.
  // SET/CLEAR with a zero operand is a pure read.
  function automatic csr_rmw_t csr_rmw(input csr_op_e op,
                                       input logic [CSR_XLEN-1:0] old,
                                       input logic [CSR_XLEN-1:0] wdata);
    csr_rmw_t r;
    r.value  = old;
    r.writes = 1'b0;
    case (op)
      CSR_WRITE: begin
        r.value  = wdata;
        r.writes = 1'b1;
      end
      CSR_SET: begin
        r.value  = old | wdata;
        r.writes = |wdata;
      end
      CSR_CLEAR: begin
        r.value  = old & ~wdata;
        r.writes = |wdata;
      end
      default: begin
        r.value  = old;
        r.writes = 1'b0;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/csr_commit_unit.sv
// CSR commit unit: takes one CSR op from the commit stage, checks privilege
// and read-only access, performs the read-modify-write on the CSR file port,
// and returns the old value or an exception. Every completed op (including
// exceptions) pulses csr_commit_o so the address buffer retires its entry.
module csr_commit_unit
  import ariane_pkg::*;
#(
  parameter int unsigned XLEN        = CSR_XLEN,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            commit_valid_i,
  output logic            commit_ready_o,
  input  logic [1:0]      op_i,
  input  logic [11:0]     addr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [1:0]      priv_lvl_i,
  output logic            done_o,
  output logic [XLEN-1:0] rdata_o,
  output logic            ex_valid_o,
  output logic [1:0]      ex_cause_o,
  output logic            csr_commit_o,
  output logic            rf_req_o,
  output logic            rf_we_o,
  output logic [11:0]     rf_addr_o,
  output logic [XLEN-1:0] rf_wdata_o,
  input  logic            rf_gnt_i,
  input  logic            rf_rvalid_i,
  input  logic [XLEN-1:0] rf_rdata_i,
  input  logic            rf_err_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_RD_REQ,
    S_RD_WAIT,
    S_WR_REQ,
    S_RESP
  } state_e;

  state_e          state;
  csr_op_e         op_reg;
  logic [11:0]     addr_reg;
  logic [XLEN-1:0] wdata_reg;
  logic [XLEN-1:0] old_reg;
  logic [1:0]      priv_reg;
  logic [15:0]     timer;

  csr_rmw_t        rmw;
  logic            writes;
  logic            priv_fail;
  logic            ro_fail;
  logic            timeout_hit;

  // The write decision depends only on op and operand, so the same result is
  // valid in CHECK (where rf_rdata_i is ignored) and in RD_WAIT.
  assign rmw         = csr_rmw(op_reg, CSR_XLEN'(rf_rdata_i), CSR_XLEN'(wdata_reg));
  assign writes      = rmw.writes;
  assign priv_fail   = addr_reg[9:8] > priv_reg;
  assign ro_fail     = (addr_reg[11:10] == CSR_RO_FIELD) && writes;
  // Fires on the TIMEOUT_CYC-th consecutive cycle in a waiting state.
  assign timeout_hit = (TIMEOUT_CYC != 0) && ((32'(timer) + 32'd1) >= TIMEOUT_CYC);
  // Address is held from acceptance to completion, so it is stable under req.
  assign rf_addr_o   = addr_reg;

  // Control FSM with registered outputs; the wait timer restarts on every state change.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= S_IDLE;
      commit_ready_o <= 1'b1;
      done_o         <= 1'b0;
      rdata_o        <= '0;
      ex_valid_o     <= 1'b0;
      ex_cause_o     <= 2'd0;
      csr_commit_o   <= 1'b0;
      rf_req_o       <= 1'b0;
      rf_we_o        <= 1'b0;
      rf_wdata_o     <= '0;
      op_reg         <= CSR_READ;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      old_reg        <= '0;
      priv_reg       <= 2'd0;
      timer          <= '0;
    end else begin
      done_o       <= 1'b0;
      csr_commit_o <= 1'b0;
      timer        <= '0;
      case (state)
        S_IDLE: begin
          if (commit_valid_i && commit_ready_o && !flush_i) begin
            op_reg         <= csr_op_e'(op_i);
            addr_reg       <= addr_i;
            wdata_reg      <= wdata_i;
            priv_reg       <= priv_lvl_i;
            commit_ready_o <= 1'b0;
            state          <= S_CHECK;
          end
        end

        S_CHECK: begin
          if (flush_i) begin
            commit_ready_o <= 1'b1;
            state          <= S_IDLE;
          end else if (priv_fail || ro_fail) begin
            done_o       <= 1'b1;
            csr_commit_o <= 1'b1;
            ex_valid_o   <= 1'b1;
            ex_cause_o   <= priv_fail ? ILLEGAL_PRIV : ILLEGAL_RO;
            rdata_o      <= '0;
            state        <= S_RESP;
          end else begin
            rf_req_o <= 1'b1;
            rf_we_o  <= 1'b0;
            state    <= S_RD_REQ;
          end
        end

        S_RD_REQ: begin
          // A grant commits the op architecturally; flush only wins before it.
          if (rf_gnt_i) begin
            rf_req_o <= 1'b0;
            state    <= S_RD_WAIT;
          end else if (flush_i) begin
            rf_req_o       <= 1'b0;
            commit_ready_o <= 1'b1;
            state          <= S_IDLE;
          end else if (timeout_hit) begin
            rf_req_o     <= 1'b0;
            done_o       <= 1'b1;
            csr_commit_o <= 1'b1;
            ex_valid_o   <= 1'b1;
            ex_cause_o   <= TIMEOUT;
            rdata_o      <= '0;
            state        <= S_RESP;
          end else begin
            timer <= timer + 16'd1;
          end
        end

        S_RD_WAIT: begin
          if (rf_rvalid_i) begin
            if (rf_err_i) begin
              done_o       <= 1'b1;
              csr_commit_o <= 1'b1;
              ex_valid_o   <= 1'b1;
              ex_cause_o   <= BUS_ERR;
              rdata_o      <= '0;
              state        <= S_RESP;
            end else if (writes) begin
              old_reg    <= rf_rdata_i;
              rf_req_o   <= 1'b1;
              rf_we_o    <= 1'b1;
              rf_wdata_o <= XLEN'(rmw.value);
              state      <= S_WR_REQ;
            end else begin
              done_o       <= 1'b1;
              csr_commit_o <= 1'b1;
              rdata_o      <= rf_rdata_i;
              state        <= S_RESP;
            end
          end else if (timeout_hit) begin
            done_o       <= 1'b1;
            csr_commit_o <= 1'b1;
            ex_valid_o   <= 1'b1;
            ex_cause_o   <= TIMEOUT;
            rdata_o      <= '0;
            state        <= S_RESP;
          end else begin
            timer <= timer + 16'd1;
          end
        end

        S_WR_REQ: begin
          if (rf_gnt_i) begin
            rf_req_o     <= 1'b0;
            rf_we_o      <= 1'b0;
            rf_wdata_o   <= '0;
            done_o       <= 1'b1;
            csr_commit_o <= 1'b1;
            rdata_o      <= old_reg;
            state        <= S_RESP;
          end else if (timeout_hit) begin
            rf_req_o     <= 1'b0;
            rf_we_o      <= 1'b0;
            rf_wdata_o   <= '0;
            done_o       <= 1'b1;
            csr_commit_o <= 1'b1;
            ex_valid_o   <= 1'b1;
            ex_cause_o   <= TIMEOUT;
            rdata_o      <= '0;
            state        <= S_RESP;
          end else begin
            timer <= timer + 16'd1;
          end
        end

        S_RESP: begin
          ex_valid_o     <= 1'b0;
          ex_cause_o     <= 2'd0;
          rdata_o        <= '0;
          commit_ready_o <= 1'b1;
          state          <= S_IDLE;
        end

        default: begin
          rf_req_o       <= 1'b0;
          rf_we_o        <= 1'b0;
          commit_ready_o <= 1'b1;
          state          <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csr_commit_unit.sv
// Testbench for csr_commit_unit: directed scenarios plus randomized ops with a
// CSR-file responder; expectations come from a cycle-count/value model.
module tb_csr_commit_unit;
  import ariane_pkg::*;

  localparam int unsigned TB_TIMEOUT = 6;
  localparam int          NEVER      = 99;
  localparam int          MAX_CYC    = 40;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        commit_valid;
  logic        commit_ready;
  logic [1:0]  op;
  logic [11:0] addr;
  logic [63:0] wdata;
  logic [1:0]  priv;
  logic        done;
  logic [63:0] rdata;
  logic        ex_valid;
  logic [1:0]  ex_cause;
  logic        csr_commit;
  logic        rf_req;
  logic        rf_we;
  logic [11:0] rf_addr;
  logic [63:0] rf_wdata;
  logic        rf_gnt;
  logic        rf_rvalid;
  logic [63:0] rf_rdata;
  logic        rf_err;

  csr_commit_unit #(.XLEN(64), .TIMEOUT_CYC(TB_TIMEOUT)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .commit_valid_i(commit_valid), .commit_ready_o(commit_ready),
    .op_i(op), .addr_i(addr), .wdata_i(wdata), .priv_lvl_i(priv),
    .done_o(done), .rdata_o(rdata), .ex_valid_o(ex_valid), .ex_cause_o(ex_cause),
    .csr_commit_o(csr_commit),
    .rf_req_o(rf_req), .rf_we_o(rf_we), .rf_addr_o(rf_addr), .rf_wdata_o(rf_wdata),
    .rf_gnt_i(rf_gnt), .rf_rvalid_i(rf_rvalid), .rf_rdata_i(rf_rdata), .rf_err_i(rf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks_total  = 0;
  int checks_passed = 0;

  logic [63:0] mem [logic [11:0]];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_total++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else
      checks_passed++;
  endtask

  // One op through the unit; gd/rd/wd are grant/rvalid/write-grant delays,
  // flush_k is the cycle (after acceptance) in which flush is pulsed (0 = none).
  task automatic run_txn(input int id, input logic [1:0] t_op, input logic [11:0] t_addr,
                         input logic [63:0] t_wdata, input logic [1:0] t_priv,
                         input int gd, input int rd, input int wd,
                         input logic t_err, input int flush_k);
    logic [63:0] old_v, new_v, exp_rdata, wval, got_rdata;
    logic        wr_needed, ex_chk, exp_ex, exp_write, abort;
    logic        done_seen, wrote, got_ex, got_commit, prev_req, prev_we, prev_gnt;
    logic [1:0]  exp_cause, got_cause;
    int          exp_done, done_cyc, rd_cnt, wr_cnt, gnt_cyc, viol, chk_req, v, win;

    if (!mem.exists(t_addr)) mem[t_addr] = {$urandom(), $urandom()};
    old_v = mem[t_addr];

    // Reference model
    wr_needed = (t_op == 2'd1) || ((t_op == 2'd2 || t_op == 2'd3) && t_wdata != 64'd0);
    case (t_op)
      2'd1:    new_v = t_wdata;
      2'd2:    new_v = old_v | t_wdata;
      2'd3:    new_v = old_v & ~t_wdata;
      default: new_v = old_v;
    endcase
    exp_ex = 1'b0; exp_cause = 2'd0; exp_rdata = 64'd0; exp_write = 1'b0; exp_done = 0;
    ex_chk = 1'b0;
    if (t_addr[9:8] > t_priv) begin
      ex_chk = 1'b1; exp_ex = 1'b1; exp_cause = 2'd0; exp_done = 2;
    end else if (t_addr[11:10] == 2'b11 && wr_needed) begin
      ex_chk = 1'b1; exp_ex = 1'b1; exp_cause = 2'd1; exp_done = 2;
    end else if (gd >= int'(TB_TIMEOUT)) begin
      exp_ex = 1'b1; exp_cause = 2'd3; exp_done = 2 + int'(TB_TIMEOUT);
    end else if (rd >= int'(TB_TIMEOUT)) begin
      exp_ex = 1'b1; exp_cause = 2'd3; exp_done = 3 + gd + int'(TB_TIMEOUT);
    end else begin
      v = 3 + gd + rd;
      if (t_err) begin
        exp_ex = 1'b1; exp_cause = 2'd2; exp_done = v + 1;
      end else if (!wr_needed) begin
        exp_rdata = old_v; exp_done = v + 1;
      end else if (wd >= int'(TB_TIMEOUT)) begin
        exp_ex = 1'b1; exp_cause = 2'd3; exp_done = v + 1 + int'(TB_TIMEOUT);
      end else begin
        exp_rdata = old_v; exp_write = 1'b1; exp_done = v + 2 + wd;
      end
    end
    win   = 1 + ((gd < int'(TB_TIMEOUT)) ? gd : int'(TB_TIMEOUT));
    abort = (flush_k == 1) || (!ex_chk && flush_k >= 2 && flush_k <= win);
    if (abort) exp_write = 1'b0;

    // Issue
    @(negedge clk);
    check("ready_before_issue", 64'(commit_ready), 64'd1);
    commit_valid = 1'b1; op = t_op; addr = t_addr; wdata = t_wdata; priv = t_priv;
    @(posedge clk);

    done_seen = 0; wrote = 0; got_ex = 0; got_commit = 0; got_cause = 0; got_rdata = 0;
    prev_req = 0; prev_we = 0; prev_gnt = 0; wval = 0;
    done_cyc = -1; rd_cnt = 0; wr_cnt = 0; gnt_cyc = -1; viol = 0; chk_req = 0;
    for (int k = 1; k <= MAX_CYC; k++) begin
      @(negedge clk);
      commit_valid = 1'b0;
      flush = (k == flush_k);
      if (rf_req) begin
        if (rf_addr != t_addr) viol++;
        if (prev_req && !prev_gnt && rf_we != prev_we) viol++;
        if (ex_chk) chk_req++;
      end
      if (done && !done_seen) begin
        done_seen = 1; done_cyc = k; got_ex = ex_valid; got_cause = ex_cause;
        got_rdata = rdata; got_commit = csr_commit;
      end
      prev_req = rf_req; prev_we = rf_we;
      rf_gnt = 1'b0; rf_rvalid = 1'b0; rf_err = 1'b0; rf_rdata = {$urandom(), $urandom()};
      if (rf_req && !rf_we) begin
        if (rd_cnt == gd) begin rf_gnt = 1'b1; gnt_cyc = k; end
        rd_cnt++;
      end
      if (gnt_cyc >= 0 && k == gnt_cyc + 1 + rd) begin
        rf_rvalid = 1'b1; rf_rdata = mem[t_addr]; rf_err = t_err;
      end
      if (rf_req && rf_we) begin
        if (wr_cnt == wd) begin rf_gnt = 1'b1; wrote = 1; wval = rf_wdata; mem[t_addr] = rf_wdata; end
        wr_cnt++;
      end
      prev_gnt = rf_gnt;
      if (done_seen) break;
    end
    @(negedge clk);
    flush = 1'b0; rf_gnt = 1'b0; rf_rvalid = 1'b0; rf_err = 1'b0;

    $display("txn %0d op=%0d addr=%03h priv=%0d gd=%0d rd=%0d wd=%0d err=%0b flush@%0d -> done=%0b@%0d ex=%0b cause=%0d rdata=%0h wrote=%0b",
             id, t_op, t_addr, t_priv, gd, rd, wd, t_err, flush_k, done_seen, done_cyc,
             got_ex, got_cause, got_rdata, wrote);

    check("done_seen", 64'(done_seen), 64'(!abort));
    check("write_done", 64'(wrote), 64'(exp_write));
    check("req_stable", 64'(viol), 64'd0);
    check("ready_after", 64'(commit_ready), 64'd1);
    check("done_one_cycle", 64'(done), 64'd0);
    if (!abort) begin
      check("done_cycle", 64'(done_cyc), 64'(exp_done));
      check("ex_valid", 64'(got_ex), 64'(exp_ex));
      if (exp_ex) check("ex_cause", 64'(got_cause), 64'(exp_cause));
      check("rdata", got_rdata, exp_rdata);
      check("commit_pulse", 64'(got_commit), 64'd1);
    end
    if (exp_write) check("write_value", wval, new_v);
    if (ex_chk && !abort) check("no_req_on_check_ex", 64'(chk_req), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  r_op, r_priv;
    logic [11:0] r_addr;
    logic [63:0] r_wdata;
    int          r_gd, r_rd, r_wd, r_fk, r;

    rst = 1'b1; flush = 1'b0; commit_valid = 1'b0; op = 2'd0; addr = '0; wdata = '0;
    priv = 2'd0; rf_gnt = 1'b0; rf_rvalid = 1'b0; rf_rdata = '0; rf_err = 1'b0;
    #12;
    check("rst_ready", 64'(commit_ready), 64'd1);
    check("rst_done", 64'(done), 64'd0);
    check("rst_req", 64'(rf_req), 64'd0);
    check("rst_commit", 64'(csr_commit), 64'd0);
    check("rst_ex", 64'(ex_valid), 64'd0);
    check("rst_rdata", rdata, 64'd0);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    // Directed scenarios
    mem[12'h300] = 64'h1;
    run_txn(1, 2'd2, 12'h300, 64'h8, 2'd3, 0, 0, 0, 1'b0, 0);     // SET -> 0x9, done c5
    run_txn(2, 2'd2, 12'hC00, 64'h0, 2'd3, 0, 0, 0, 1'b0, 0);     // RO read via SET 0, c4
    run_txn(3, 2'd1, 12'hC01, 64'h5, 2'd3, 0, 0, 0, 1'b0, 0);     // ILLEGAL_RO c2
    run_txn(4, 2'd0, 12'h300, 64'h0, 2'd0, 0, 0, 0, 1'b0, 0);     // ILLEGAL_PRIV
    run_txn(5, 2'd2, 12'h341, 64'h3, 2'd3, 5, 0, 0, 1'b1, 0);     // held gnt, BUS_ERR
    run_txn(6, 2'd0, 12'h100, 64'h0, 2'd1, NEVER, 0, 0, 1'b0, 0); // TIMEOUT on read req
    run_txn(7, 2'd1, 12'h101, 64'h7, 2'd1, 0, 0, NEVER, 1'b0, 0); // TIMEOUT on write req
    run_txn(8, 2'd0, 12'h000, 64'h0, 2'd0, 3, 0, 0, 1'b0, 2);     // flush in RD_REQ
    run_txn(9, 2'd1, 12'h001, 64'hA, 2'd0, 0, 2, 0, 1'b0, 3);     // flush after gnt ignored
    run_txn(10, 2'd1, 12'hC02, 64'h1, 2'd3, 0, 0, 0, 1'b0, 1);    // flush in CHECK

    // Flush in IDLE blocks acceptance
    @(negedge clk);
    commit_valid = 1'b1; flush = 1'b1; op = 2'd0; addr = 12'h002; priv = 2'd3;
    @(negedge clk);
    commit_valid = 1'b0; flush = 1'b0;
    check("idle_flush_ready", 64'(commit_ready), 64'd1);
    repeat (3) @(negedge clk);
    check("idle_flush_no_req", 64'(rf_req), 64'd0);

    // Async reset during WR_REQ
    @(negedge clk);
    commit_valid = 1'b1; op = 2'd1; addr = 12'h003; wdata = 64'h55; priv = 2'd0;
    @(negedge clk);                    // c1 CHECK
    commit_valid = 1'b0;
    @(negedge clk);                    // c2 RD_REQ
    rf_gnt = 1'b1;
    @(negedge clk);                    // c3 RD_WAIT
    rf_gnt = 1'b0; rf_rvalid = 1'b1; rf_rdata = 64'h12;
    @(negedge clk);                    // c4 WR_REQ
    rf_rvalid = 1'b0;
    check("wrreq_before_rst", 64'(rf_req & rf_we), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_req", 64'(rf_req), 64'd0);
    check("rst_mid_ready", 64'(commit_ready), 64'd1);
    check("rst_mid_done", 64'(done), 64'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_done", 64'(done), 64'd0);
    check("post_rst_commit", 64'(csr_commit), 64'd0);

    // Randomized ops
    for (int n = 0; n < 70; n++) begin
      r_op    = 2'($urandom_range(0, 3));
      r_addr  = 12'($urandom()) & 12'hF03;
      r_priv  = 2'($urandom_range(0, 3));
      r_wdata = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom(), $urandom()};
      r = $urandom_range(0, 9); r_gd = (r < 7) ? $urandom_range(0, 2) : ((r < 9) ? 5 : NEVER);
      r = $urandom_range(0, 9); r_rd = (r < 7) ? $urandom_range(0, 2) : ((r < 9) ? 5 : NEVER);
      r = $urandom_range(0, 9); r_wd = (r < 7) ? $urandom_range(0, 2) : ((r < 9) ? 5 : NEVER);
      r_fk = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 6) : 0;
      run_txn(100 + n, r_op, r_addr, r_wdata, r_priv, r_gd, r_rd, r_wd,
              ($urandom_range(0, 7) == 0), r_fk);
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
